// File: rtl/udma_stream_arbiter.sv
// rtl/udma_stream_arbiter.sv - round-robin burst-aware arbiter feeding one uDMA stream FIFO source port.
// Optional id_o output (binary index of the granted channel) is built when UDMA_ARB_ID_EN is defined.
module udma_stream_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_i,
    input  logic [N_CH-1:0]              ch_valid_i,
    input  logic [N_CH-1:0]              ch_last_i,
    output logic [N_CH-1:0]              ch_ready_o,
    output logic [DATA_WIDTH-1:0]        fifo_data_o,
    output logic                         fifo_valid_o,
    input  logic                         fifo_ready_i,
    output logic [N_CH-1:0]              grant_o,
    output logic                         busy_o
`ifdef UDMA_ARB_ID_EN
    ,
    output logic [$clog2(N_CH)-1:0]      id_o
`endif
);

    localparam int PW = $clog2(N_CH);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [PW-1:0] LAST_CH   = PW'(N_CH - 1);
    localparam logic [PW:0]   N_CH_EXT  = (PW + 1)'(N_CH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [N_CH-1:0] grant;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   pick_idx;
    logic [PW:0]     scan_idx;
    logic            found;
    logic            any_req;
    logic            hs;
    logic            release_grant;

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) g_idx = PW'(k);
        end
    end

    // Scan upward from rr_ptr with explicit wrap so non-power-of-two N_CH works.
    always_comb begin
        pick_idx = rr_ptr;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (scan_idx >= N_CH_EXT) scan_idx = scan_idx - N_CH_EXT;
            if (!found && ch_valid_i[scan_idx[PW-1:0]]) begin
                pick_idx = scan_idx[PW-1:0];
                found    = 1'b1;
            end
        end
    end

    assign any_req = |ch_valid_i;

    // Data path stays combinational; everything is forced to zero outside GRANT.
    always_comb begin
        fifo_data_o  = '0;
        fifo_valid_o = 1'b0;
        ch_ready_o   = '0;
        if (state == GRANT) begin
            fifo_data_o       = ch_data_i[g_idx*DATA_WIDTH +: DATA_WIDTH];
            fifo_valid_o      = ch_valid_i[g_idx];
            ch_ready_o[g_idx] = fifo_ready_i;
        end
    end

    assign hs = fifo_valid_o & fifo_ready_i;

    assign release_grant = (state == GRANT) &&
                           (!ch_valid_i[g_idx] ||
                            (hs && (ch_last_i[g_idx] || (beat_cnt == LAST_BEAT))));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= N_CH'(1) << pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state    <= IDLE;
                        grant    <= '0;
                        beat_cnt <= '0;
                        rr_ptr   <= (g_idx == LAST_CH) ? '0 : g_idx + 1'b1;
                    end else if (hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign grant_o = grant;
    assign busy_o  = (state == GRANT);

`ifdef UDMA_ARB_ID_EN
    assign id_o = g_idx;
`endif

endmodule

// File: tb/tb_udma_stream_arbiter.sv
// tb/tb_udma_stream_arbiter.sv - self-checking bench for udma_stream_arbiter with a queue-based reference model.
module tb_udma_stream_arbiter;

    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int MAXB = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH*DW-1:0]   ch_data;
    logic [N_CH-1:0]      ch_valid;
    logic [N_CH-1:0]      ch_last;
    logic [N_CH-1:0]      ch_ready;
    logic [DW-1:0]        fifo_data;
    logic                 fifo_valid;
    logic                 fifo_ready;
    logic [N_CH-1:0]      grant;
    logic                 busy;
`ifdef UDMA_ARB_ID_EN
    logic [1:0]           id;
`endif

    always #5 clk = ~clk;

    udma_stream_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_data_i    (ch_data),
        .ch_valid_i   (ch_valid),
        .ch_last_i    (ch_last),
        .ch_ready_o   (ch_ready),
        .fifo_data_o  (fifo_data),
        .fifo_valid_o (fifo_valid),
        .fifo_ready_i (fifo_ready),
        .grant_o      (grant),
        .busy_o       (busy)
`ifdef UDMA_ARB_ID_EN
        ,
        .id_o         (id)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t q [N_CH][$];
    int    glog[$];
    int    blen[$];
    int    m_owner, m_ptr, m_cnt;
    int    n_checks, n_fail;
    int    rdy_mode;
    int    cyc;

    function automatic int total_pending();
        int t = 0;
        for (int k = 0; k < N_CH; k++) t += q[k].size();
        return t;
    endfunction

    function automatic longint code_of(input bit use_blen);
        longint c = 0;
        if (use_blen) for (int i = 0; i < blen.size(); i++) c = c * 10 + longint'(blen[i] + 1);
        else          for (int i = 0; i < glog.size(); i++) c = c * 10 + longint'(glog[i] + 1);
        return c;
    endfunction

    task automatic push_beats(input int ch, input int n, input int base, input bit last_at_end);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = DW'(base + i);
            b.last = last_at_end && (i == n - 1);
            q[ch].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N_CH; k++) begin
            if (q[k].size() > 0) begin
                ch_valid[k]         = 1'b1;
                ch_data[k*DW +: DW] = q[k][0].data;
                ch_last[k]          = q[k][0].last;
            end else begin
                ch_valid[k]         = 1'b0;
                ch_data[k*DW +: DW] = $urandom;
                ch_last[k]          = 1'($urandom_range(0, 1));
            end
        end
        case (rdy_mode)
            0:       fifo_ready = 1'b1;
            1:       fifo_ready = ($urandom_range(0, 3) != 0);
            default: fifo_ready = !(cyc >= 3 && cyc < 8);
        endcase
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic step();
        logic [N_CH-1:0] e_grant, e_ready;
        logic            e_valid, e_hs, e_last;
        logic [DW-1:0]   e_data;
        int              c;
        @(negedge clk);
        drive_inputs();
        #1;
        e_grant = '0; e_ready = '0; e_valid = 1'b0; e_data = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid          = (q[m_owner].size() > 0);
            e_data           = ch_data[m_owner*DW +: DW];
            e_ready[m_owner] = fifo_ready;
        end
        n_checks++;
        if (grant !== e_grant) begin n_fail++; $display("FAIL grant cyc=%0d actual=%b expected=%b", cyc, grant, e_grant); end
        n_checks++;
        if (busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL busy cyc=%0d actual=%b expected=%b", cyc, busy, (m_owner >= 0)); end
        n_checks++;
        if (fifo_valid !== e_valid) begin n_fail++; $display("FAIL fifo_valid cyc=%0d actual=%b expected=%b", cyc, fifo_valid, e_valid); end
        n_checks++;
        if (fifo_data !== e_data) begin n_fail++; $display("FAIL fifo_data cyc=%0d actual=%h expected=%h", cyc, fifo_data, e_data); end
        n_checks++;
        if (ch_ready !== e_ready) begin n_fail++; $display("FAIL ch_ready cyc=%0d actual=%b expected=%b", cyc, ch_ready, e_ready); end
`ifdef UDMA_ARB_ID_EN
        n_checks++;
        if (id !== 2'((m_owner < 0) ? 0 : m_owner)) begin n_fail++; $display("FAIL id cyc=%0d actual=%0d expected=%0d", cyc, id, (m_owner < 0) ? 0 : m_owner); end
`endif
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k] && (glog.size() == blen.size()) && (m_cnt == 0) && e_grant[k] && !(fifo_valid && fifo_ready && blen.size() > 0 && blen[blen.size()-1] > 0 && glog[glog.size()-1] == k && 1'b0)) begin
            end
        end
        if (m_owner < 0) begin
            for (int i = 0; i < N_CH; i++) begin
                c = (m_ptr + i) % N_CH;
                if (m_owner < 0 && q[c].size() > 0) begin
                    m_owner = c;
                    m_cnt   = 0;
                    glog.push_back(c);
                    blen.push_back(0);
                end
            end
        end else begin
            e_hs   = e_valid && fifo_ready;
            e_last = e_valid && q[m_owner][0].last;
            if (e_hs) begin
                void'(q[m_owner].pop_front());
                blen[blen.size()-1] = blen[blen.size()-1] + 1;
            end
            if (!e_valid || (e_hs && (e_last || m_cnt + 1 == MAXB))) begin
                m_ptr   = (m_owner + 1) % N_CH;
                m_owner = -1;
                m_cnt   = 0;
            end else if (e_hs) begin
                m_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((total_pending() > 0 || m_owner >= 0) && n < maxc) begin
            step();
            n++;
        end
        n_checks++;
        if (total_pending() > 0 || m_owner >= 0) begin
            n_fail++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", total_pending());
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N_CH; k++) q[k].delete();
        glog.delete(); blen.delete();
        m_owner = -1; m_ptr = 0; m_cnt = 0; cyc = 0; rdy_mode = 0;
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_valid = '1; ch_last = '0; fifo_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) ch_data[k*DW +: DW] = $urandom;
        @(posedge clk);
        #1;
        n_checks++; if (grant !== '0)      begin n_fail++; $display("FAIL reset_grant actual=%b required=0", grant); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++; if (fifo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%b required=0", fifo_valid); end
        n_checks++; if (fifo_data !== '0)  begin n_fail++; $display("FAIL reset_data actual=%h required=0", fifo_data); end
        n_checks++; if (ch_ready !== '0)   begin n_fail++; $display("FAIL reset_ready actual=%b required=0", ch_ready); end
        do_reset();
    endtask

    task automatic test_single_requester();
        do_reset();
        push_beats(2, 3, 32'h200, 1'b1);
        drain(20);
        n_checks++; if (code_of(0) !== 64'd3) begin n_fail++; $display("FAIL single_grants actual=%0d required=3", code_of(0)); end
        n_checks++; if (code_of(1) !== 64'd4) begin n_fail++; $display("FAIL single_beats actual=%0d required=4", code_of(1)); end
        push_beats(1, 1, 32'h100, 1'b1);
        push_beats(3, 1, 32'h300, 1'b1);
        drain(20);
        n_checks++; if (code_of(0) !== 64'd342) begin n_fail++; $display("FAIL single_rrptr actual=%0d required=342", code_of(0)); end
    endtask

    task automatic test_burst_cap();
        do_reset();
        push_beats(0, 20, 32'hA000, 1'b0);
        drain(60);
        n_checks++; if (code_of(0) !== 64'd111) begin n_fail++; $display("FAIL cap_grants actual=%0d required=111", code_of(0)); end
        n_checks++; if (code_of(1) !== 64'd995) begin n_fail++; $display("FAIL cap_beats actual=%0d required=995", code_of(1)); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < N_CH; k++) begin
            push_beats(k, 2, 32'h1000 * (k + 1), 1'b1);
            push_beats(k, 2, 32'h1000 * (k + 1) + 16, 1'b1);
        end
        drain(60);
        n_checks++; if (code_of(0) !== 64'd12341234) begin n_fail++; $display("FAIL fair_order actual=%0d required=12341234", code_of(0)); end
        n_checks++; if (code_of(1) !== 64'd33333333) begin n_fail++; $display("FAIL fair_beats actual=%0d required=33333333", code_of(1)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_beats(1, 6, 32'h1000, 1'b1);
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i >= 3) begin
                n_checks++;
                if (ch_ready[1] !== 1'b0 || busy !== 1'b1 || fifo_data !== 32'h1002) begin
                    n_fail++;
                    $display("FAIL stall cyc=%0d actual_ready=%b busy=%b data=%h required_ready=0 busy=1 data=00001002", i, ch_ready[1], busy, fifo_data);
                end
            end
        end
        drain(30);
        n_checks++; if (code_of(0) !== 64'd2) begin n_fail++; $display("FAIL stall_grants actual=%0d required=2", code_of(0)); end
        n_checks++; if (code_of(1) !== 64'd7) begin n_fail++; $display("FAIL stall_beats actual=%0d required=7", code_of(1)); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        push_beats(3, 5, 32'h3000, 1'b0);
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        drive_inputs();
        #1;
        n_checks++; if (fifo_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid actual=%b required=1", fifo_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (fifo_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid actual=%b required=0", fifo_valid); end
        n_checks++; if (grant !== '0)        begin n_fail++; $display("FAIL midrst_grant actual=%b required=0", grant); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL midrst_busy actual=%b required=0", busy); end
        do_reset();
        push_beats(0, 1, 32'h10, 1'b1);
        push_beats(3, 1, 32'h30, 1'b1);
        drain(20);
        n_checks++; if (code_of(0) !== 64'd14) begin n_fail++; $display("FAIL midrst_order actual=%0d required=14", code_of(0)); end
    endtask

    task automatic test_random();
        do_reset();
        rdy_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N_CH; k++) begin
                int n = $urandom_range(0, 14);
                beat_t b;
                for (int i = 0; i < n; i++) begin
                    b.data = $urandom;
                    b.last = ($urandom_range(0, 3) == 0);
                    q[k].push_back(b);
                end
            end
            drain(2000);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_owner = -1; m_ptr = 0; m_cnt = 0; cyc = 0; rdy_mode = 0;
        rst = 1'b1; ch_valid = '0; ch_last = '0; ch_data = '0; fifo_ready = 1'b0;
        test_reset();
        test_single_requester();
        test_burst_cap();
        test_fairness();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
